// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the pipeline's IF/MEM ports, the shared memory and the arbiter.
// master = arbiter side, slave = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;

    logic          mm_req;
    logic          mm_we;
    logic [AW-1:0] mm_addr;
    logic [DW-1:0] mm_wdata;
    logic [DW-1:0] mm_rdata;
    logic          mm_ready;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          gnt_mm;
    logic          stall;

    modport master (
        input  if_req, if_addr, mm_req, mm_we, mm_addr, mm_wdata, mem_rdata,
        output if_rdata, if_ready, mm_rdata, mm_ready,
               mem_en, mem_we, mem_addr, mem_wdata, gnt_mm, stall
    );

    modport slave (
        output if_req, if_addr, mm_req, mm_we, mm_addr, mm_wdata, mem_rdata,
        input  if_rdata, if_ready, mm_rdata, mm_ready,
               mem_en, mem_we, mem_addr, mem_wdata, gnt_mm, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between IF and MEM stage; MEM has fixed priority.
// Each access runs WAIT_CYCLES+1 ACCESS cycles, then a DONE cycle pulses the ready.
module mem_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int          AW          = 32,
    parameter int          DW          = 32
) (
    input  logic                clock,
    input  logic                resetn,
    mem_port_arbiter_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          gnt_q, gnt_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] mm_rdata_q, mm_rdata_d;
    logic          if_ready_q, if_ready_d;
    logic          mm_ready_q, mm_ready_d;
    logic          take_mm, take_if;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            gnt_q      <= 1'b0;
            if_rdata_q <= '0;
            mm_rdata_q <= '0;
            if_ready_q <= 1'b0;
            mm_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            gnt_q      <= gnt_d;
            if_rdata_q <= if_rdata_d;
            mm_rdata_q <= mm_rdata_d;
            if_ready_q <= if_ready_d;
            mm_ready_q <= mm_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        gnt_d      = gnt_q;
        if_rdata_d = if_rdata_q;
        mm_rdata_d = mm_rdata_q;
        if_ready_d = 1'b0;
        mm_ready_d = 1'b0;
        take_mm    = 1'b0;
        take_if    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.mm_req)      take_mm = 1'b1;
                else if (bus.if_req) take_if = 1'b1;
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (gnt_q) begin
                        mm_ready_d = 1'b1;
                        if (!we_q) mm_rdata_d = bus.mem_rdata;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            DONE: begin
                // The served port still holds req here, so only the other side may be granted.
                if (gnt_q && bus.if_req)       take_if = 1'b1;
                else if (!gnt_q && bus.mm_req) take_mm = 1'b1;
                else                           state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (take_mm) begin
            addr_d  = bus.mm_addr;
            wdata_d = bus.mm_wdata;
            we_d    = bus.mm_we;
            gnt_d   = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = ACCESS;
        end else if (take_if) begin
            addr_d  = bus.if_addr;
            we_d    = 1'b0;
            gnt_d   = 1'b0;
            cnt_d   = CNT_INIT;
            state_d = ACCESS;
        end
    end

    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_we    = (state_q == ACCESS) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mm_rdata  = mm_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.mm_ready  = mm_ready_q;
    assign bus.gnt_mm    = gnt_q;
    // Ready is registered, so stall drops in the same cycle the pulse is seen.
    assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.mm_req & ~mm_ready_q);
endmodule
